alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle register-register execute sequencer for the 16-bit, 8-register RISC machine.
- Sits directly on the regfile ports:
  - drives readnum to fetch two operands from data_out;
  - shifts and computes the result;
  - writes the result back through data_in/writenum/write.
- Owns operand latches A and B, result register C and the status flags.

Parameters:
- DW, 16, datapath width (regfile word width).
- RW, 3, register-number width (8 registers).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in WAIT.
- op  in  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~Bsh).
- shift  in  2  applied to B: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (MSB kept).
- rn  in  RW  source register for operand A.
- rm  in  RW  source register for operand B.
- rd  in  RW  destination register.
- wb_en  in  1  1 = write result back; 0 = flags only (compare).
- rf_data_out  in  DW  regfile data_out (combinational read of readnum).
- readnum  out  RW  regfile read select.
- writenum  out  RW  regfile write select.
- write  out  1  regfile write enable.
- data_in  out  DW  regfile write data (= C).
- result  out  DW  C register.
- status  out  3  {N,V,Z}.
- busy  out  1  high in every state except WAIT.
- done  out  1  one-cycle pulse in WB.

Behaviour:
- Reset (asynchronous, immediate):
  - state = WAIT;
  - A, B, C, status, latched fields = 0;
  - write = 0, readnum = 0, writenum = 0, busy = 0, done = 0.
  - Reset mid-operation aborts the operation; no regfile write occurs.
- FSM (Moore outputs decoded from the state register):
  - WAIT: readnum = 0, write = 0. Edge with start = 1 latches op/shift/rn/rm/rd/wb_en, then goes to GET_A. start = 0 stays in WAIT.
  - GET_A: readnum = rn_l. Edge: A <= rf_data_out, then GET_B.
  - GET_B: readnum = rm_l. Edge: B <= rf_data_out, then EXEC.
  - EXEC: edge sets C <= alu(A, shift(B)) and status <= flags, then WB.
  - WB: writenum = rd_l, data_in = C, write = wb_en_l, done = 1. Edge commits the regfile write (if enabled), then WAIT.
- Latency:
  - start edge to done-high cycle is 4 cycles.
  - Back-to-back start is accepted in the cycle after WB, giving 5 cycles per operation.
- Command and input rules:
  - start while busy is ignored and not queued.
  - Inputs other than start are don't-care after the start edge, because the latched copies are used.
- Arithmetic (DW bits, carry-out discarded):
  - SUB = A - Bsh (two's complement).
  - Z = (C == 0); N = C[DW-1].
  - V = signed overflow for ADD/SUB; V = 0 for AND/MVN.
- Register hazards:
  - rn = rm = rd is legal; operands are captured before the writeback.
  - A result written to rd is visible to a following operation's GET_A.
- writenum holds rd_l only in WB and is 0 otherwise; data_in always equals C.

Decomposition:
- Package rm_pkg holds:
  - op_t (OP_ADD, OP_SUB, OP_AND, OP_MVN);
  - shift_t (SH_NONE, SH_LSL, SH_LSR, SH_ASR);
  - state_t (S_WAIT, S_GET_A, S_GET_B, S_EXEC, S_WB);
  - DW/RW defaults;
  - status bit indices N = 2, V = 1, Z = 0.
- One combinational sub-module, exec_alu: shifter plus ALU plus flag generation. Inputs A, B, op, shift; outputs result and {N,V,Z}.
- The sequencer holds the FSM and registers only.

Test Plan (bench instantiates alu_sequencer with the real regfile; R0..R7 preloaded via a bench-side write path):
- R1 = 0x0003, R2 = 0x0005; ADD rd = 3, rn = 1, rm = 2, shift 00 -> done in 4th cycle after start; R3 = 0x0008; status = 000.
- R1 = 0x7FFF, R2 = 0x0001; ADD rd = 4 -> R4 = 0x8000; status N = 1, V = 1, Z = 0.
- R5 = 0x0004, R6 = 0x0002, shift 01; SUB, wb_en = 0 -> status Z = 1 (4 - 4); write never asserted; all registers unchanged.
- R7 = 0x8002, shift 11, MVN rd = 0 -> Bsh = 0xC001; R0 = 0x3FFE; N = 0, Z = 0, V = 0. Repeat with shift 10 -> Bsh = 0x4001; R0 = 0xBFFE; N = 1.
- start pulsed in GET_B of op1 -> ignored; exactly one write; busy low only after WB.
- reset asserted during EXEC -> outputs zero immediately (same timestep); write = 0; rd unchanged; next start runs normally.

Source files
------------

// File: rtl/rm_pkg.sv
// Shared types and constants for the register-register execute sequencer.
// Imported by the sequencer top and its combinational ALU.
package rm_pkg;

   localparam int unsigned DW_DEF = 16;
   localparam int unsigned RW_DEF = 3;

   localparam int unsigned ST_N = 2;
   localparam int unsigned ST_V = 1;
   localparam int unsigned ST_Z = 0;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_MVN = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL  = 2'b01,
      SH_LSR  = 2'b10,
      SH_ASR  = 2'b11
   } shift_t;

   typedef enum logic [2:0] {
      S_WAIT  = 3'd0,
      S_GET_A = 3'd1,
      S_GET_B = 3'd2,
      S_EXEC  = 3'd3,
      S_WB    = 3'd4
   } state_t;

endpackage

// File: rtl/alu_sequencer_exec_alu.sv
// Combinational B-operand shifter, ALU and {N,V,Z} flag generation.
// Carry-out is discarded; V is only meaningful for ADD/SUB.
module exec_alu
   import rm_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  op_t           op,
   input  shift_t        shift,
   output logic [DW-1:0] result,
   output logic [2:0]    status
);

   logic [DW-1:0] b_sh;
   logic          ovf;

   always_comb begin
      b_sh = b;
      unique case (shift)
         SH_NONE: b_sh = b;
         SH_LSL:  b_sh = {b[DW-2:0], 1'b0};
         SH_LSR:  b_sh = {1'b0, b[DW-1:1]};
         SH_ASR:  b_sh = {b[DW-1], b[DW-1:1]};
         default: b_sh = b;
      endcase
   end

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      unique case (op)
         OP_ADD: begin
            result = a + b_sh;
            // same-sign operands producing an opposite-sign sum
            ovf    = (a[DW-1] == b_sh[DW-1]) && (result[DW-1] != a[DW-1]);
         end
         OP_SUB: begin
            result = a - b_sh;
            ovf    = (a[DW-1] != b_sh[DW-1]) && (result[DW-1] != a[DW-1]);
         end
         OP_AND: result = a & b_sh;
         OP_MVN: result = ~b_sh;
         default: result = '0;
      endcase
   end

   always_comb begin
      status       = '0;
      status[ST_N] = result[DW-1];
      status[ST_V] = ovf;
      status[ST_Z] = (result == '0);
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute sequencer: reads two operands from the regfile, computes
// through exec_alu, and optionally writes the result back. Moore-decoded outputs.
module alu_sequencer
   import rm_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned RW = RW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [1:0]    shift,
   input  logic [RW-1:0] rn,
   input  logic [RW-1:0] rm,
   input  logic [RW-1:0] rd,
   input  logic          wb_en,
   input  logic [DW-1:0] rf_data_out,
   output logic [RW-1:0] readnum,
   output logic [RW-1:0] writenum,
   output logic          write,
   output logic [DW-1:0] data_in,
   output logic [DW-1:0] result,
   output logic [2:0]    status,
   output logic          busy,
   output logic          done
);

   state_t        state, state_nxt;
   op_t           op_l;
   shift_t        shift_l;
   logic [RW-1:0] rn_l, rm_l, rd_l;
   logic          wb_en_l;
   logic [DW-1:0] a_q, b_q, c_q;
   logic [2:0]    status_q;
   logic [DW-1:0] alu_res;
   logic [2:0]    alu_st;

   exec_alu #(.DW(DW)) u_exec_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (op_l),
      .shift  (shift_l),
      .result (alu_res),
      .status (alu_st)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_WAIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_WAIT:  if (start) state_nxt = S_GET_A;
         S_GET_A: state_nxt = S_GET_B;
         S_GET_B: state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         S_WB:    state_nxt = S_WAIT;
         default: state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_l     <= OP_ADD;
         shift_l  <= SH_NONE;
         rn_l     <= '0;
         rm_l     <= '0;
         rd_l     <= '0;
         wb_en_l  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status_q <= '0;
      end else begin
         unique case (state)
            S_WAIT: if (start) begin
               op_l    <= op_t'(op);
               shift_l <= shift_t'(shift);
               rn_l    <= rn;
               rm_l    <= rm;
               rd_l    <= rd;
               wb_en_l <= wb_en;
            end
            S_GET_A: a_q <= rf_data_out;
            S_GET_B: b_q <= rf_data_out;
            S_EXEC: begin
               c_q      <= alu_res;
               status_q <= alu_st;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      done     = 1'b0;
      busy     = (state != S_WAIT);
      unique case (state)
         S_GET_A: readnum = rn_l;
         S_GET_B: readnum = rm_l;
         S_WB: begin
            writenum = rd_l;
            write    = wb_en_l;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

   assign data_in = c_q;
   assign result  = c_q;
   assign status  = status_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer attached to a bench-side 8x16 regfile.
module tb_alu_sequencer;
   import rm_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op, shift;
   logic [2:0]  rn, rm, rd;
   logic        wb_en;
   logic [15:0] rf_data_out;
   logic [2:0]  readnum, writenum;
   logic        write;
   logic [15:0] data_in, result;
   logic [2:0]  status;
   logic        busy, done;

   logic [15:0] rf [8];
   logic [15:0] model [8];
   logic        tb_we;
   logic [2:0]  tb_wn;
   logic [15:0] tb_wd;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  st;
      logic        wb;
      logic [2:0]  rd;
   } exp_t;
   exp_t exp_q[$];

   int n_chk  = 0;
   int n_pass = 0;
   int wr_count = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.DW(16), .RW(3)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .shift(shift),
      .rn(rn), .rm(rm), .rd(rd), .wb_en(wb_en), .rf_data_out(rf_data_out),
      .readnum(readnum), .writenum(writenum), .write(write), .data_in(data_in),
      .result(result), .status(status), .busy(busy), .done(done)
   );

   always_ff @(posedge clk) begin
      if (tb_we)      rf[tb_wn]    <= tb_wd;
      else if (write) rf[writenum] <= data_in;
   end
   assign rf_data_out = rf[readnum];

   always @(posedge clk) if (write) wr_count++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every done cycle is matched against the oldest expected response.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("status", 32'(status), 32'(e.st));
            chk("data_in", 32'(data_in), 32'(e.res));
            chk("write", 32'(write), 32'(e.wb));
            chk("writenum", 32'(writenum), e.wb ? 32'(e.rd) : 32'(e.rd));
            chk("busy_in_wb", 32'(busy), 32'd1);
         end
      end
   end

   task automatic preload(input logic [2:0] r, input logic [15:0] v);
      @(negedge clk);
      tb_we = 1'b1; tb_wn = r; tb_wd = v;
      @(negedge clk);
      tb_we = 1'b0;
      model[r] = v;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_R%0d", tag, i), 32'(rf[i]), 32'(model[i]));
   endtask

   task automatic run_op(input logic [1:0] o, input logic [1:0] s, input logic [2:0] n,
                         input logic [2:0] m, input logic [2:0] d, input logic w,
                         input logic [15:0] eres, input logic [2:0] est,
                         input bit inject_start);
      int cyc;
      int wr0;
      exp_t e;
      e.res = eres; e.st = est; e.wb = w; e.rd = d;
      exp_q.push_back(e);
      wr0 = wr_count;
      @(negedge clk);
      op = o; shift = s; rn = n; rm = m; rd = d; wb_en = w; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 2'b11; shift = 2'b11; rn = 3'd7; rm = 3'd7; rd = 3'd7; wb_en = 1'b1;
      cyc = 1;
      while (done !== 1'b1 && cyc < 12) begin
         if (inject_start && cyc == 2) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      chk("latency", 32'(cyc), 32'd4);
      @(posedge clk); #1;
      chk("busy_after_wb", 32'(busy), 32'd0);
      if (w) model[d] = eres;
      @(negedge clk);
      chk("write_count", 32'(wr_count - wr0), w ? 32'd1 : 32'd0);
      check_regs("regs");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int wr0;
      reset = 1'b1; start = 1'b0; op = '0; shift = '0; rn = '0; rm = '0; rd = '0;
      wb_en = 1'b0; tb_we = 1'b0; tb_wn = '0; tb_wd = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_readnum", 32'(readnum), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);

      preload(3'd1, 16'h0003); preload(3'd2, 16'h0005);
      run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0008, 3'b000, 1'b0);

      preload(3'd1, 16'h7FFF); preload(3'd2, 16'h0001);
      run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd4, 1'b1, 16'h8000, 3'b110, 1'b0);

      preload(3'd5, 16'h0004); preload(3'd6, 16'h0002);
      run_op(2'b01, 2'b01, 3'd5, 3'd6, 3'd1, 1'b0, 16'h0000, 3'b001, 1'b0);

      preload(3'd7, 16'h8002);
      run_op(2'b11, 2'b11, 3'd1, 3'd7, 3'd0, 1'b1, 16'h3FFE, 3'b000, 1'b0);
      run_op(2'b11, 2'b10, 3'd1, 3'd7, 3'd0, 1'b1, 16'hBFFE, 3'b100, 1'b0);

      // start pulsed during GET_B must be dropped
      run_op(2'b00, 2'b00, 3'd0, 3'd1, 3'd2, 1'b1, 16'h3FFD, 3'b000, 1'b1);

      // rn = rm = rd, then the new R1 feeds the next GET_A
      run_op(2'b00, 2'b00, 3'd1, 3'd1, 3'd1, 1'b1, 16'hFFFE, 3'b110, 1'b0);
      run_op(2'b01, 2'b00, 3'd1, 3'd3, 3'd5, 1'b1, 16'hFFF6, 3'b100, 1'b0);

      // reset during EXEC aborts without a write
      wr0 = wr_count;
      @(negedge clk);
      op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd3; rd = 3'd6; wb_en = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_write", 32'(write), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_status", 32'(status), 32'd0);
      chk("abort_data_in", 32'(data_in), 32'd0);
      chk("abort_writenum", 32'(writenum), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("abort_write_count", 32'(wr_count - wr0), 32'd0);
      check_regs("abort");

      run_op(2'b10, 2'b00, 3'd4, 3'd3, 3'd7, 1'b1, 16'h0000, 3'b001, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
